// File: rtl/ddr5_cmd_scheduler.sv
// Closed-page DDR5 command sequencer: one request at a time, ACT0/ACT1, RD/WR pair, PRE.
// Define DDR5_REFRESH_EN to add periodic all-bank refresh (REF + tRFC wait).
module ddr5_cmd_scheduler #(
    parameter int unsigned T_RCD  = 39,
    parameter int unsigned T_RAS  = 76,
    parameter int unsigned T_RTP  = 18,
    parameter int unsigned T_WR   = 118,
    parameter int unsigned T_RP   = 39,
    parameter int unsigned T_RFC  = 708,
    parameter int unsigned T_REFI = 9360
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_op,
    input  logic [35:0] i_req_addr,
    output logic [3:0]  o_cmd_code,
    output logic        o_cmd_channel,
    output logic [2:0]  o_cmd_bg,
    output logic [1:0]  o_cmd_bank,
    output logic [15:0] o_cmd_row,
    output logic [5:0]  o_cmd_col,
    output logic        o_req_done,
    output logic        o_ref_active
);
    localparam int unsigned M0 = (T_RCD > T_RAS) ? T_RCD : T_RAS;
    localparam int unsigned M1 = (T_RTP > T_WR) ? T_RTP : T_WR;
    localparam int unsigned M2 = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int unsigned M3 = (M0 > M1) ? M0 : M1;
    localparam int unsigned M4 = (M2 > T_REFI) ? M2 : T_REFI;
    localparam int unsigned MaxT = (M3 > M4) ? M3 : M4;
    localparam int unsigned CW = $clog2(MaxT) + 1;
    localparam logic [CW-1:0] One = CW'(1);

    localparam logic [3:0] CmdNop = 4'd0, CmdAct0 = 4'd1, CmdAct1 = 4'd2, CmdRd0 = 4'd3;
    localparam logic [3:0] CmdRd1 = 4'd4, CmdWr0 = 4'd5, CmdWr1 = 4'd6, CmdPre = 4'd7;
    localparam logic [3:0] CmdRef = 4'd8;

    typedef enum logic [3:0] {
        StIdle, StAct0, StAct1, StTrcd, StCol0, StCol1, StTpre, StPre, StTrp
`ifdef DDR5_REFRESH_EN
        , StRef, StTrfc
`endif
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_wait;
    logic [CW-1:0]  r_ras;
    logic           r_wr;
    logic           r_ready;
    logic [3:0]     r_cmd;
    logic           r_done;
    logic           r_ch;
    logic [2:0]     r_bg;
    logic [1:0]     r_bank;
    logic [15:0]    r_row;
    logic [5:0]     r_col;
    logic           w_accept;
    logic           w_ref_pending;
    logic           w_unused;

    assign w_accept = i_req_valid && r_ready;
    assign w_unused = ^{i_req_addr[35:34], i_req_addr[5:0]};

`ifdef DDR5_REFRESH_EN
    logic [CW-1:0]  r_refi;
    logic           r_ref_pending;
    logic           r_ref_active;
    assign w_ref_pending = r_ref_pending;
    assign o_ref_active  = r_ref_active;
`else
    assign w_ref_pending = 1'b0;
    assign o_ref_active  = 1'b0;
`endif

    // Both counters count down to zero; a wait ends the cycle before the counter would pass 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_wait  <= '0;
            r_ras   <= '0;
            r_wr    <= 1'b0;
            r_ready <= 1'b0;
            r_cmd   <= CmdNop;
            r_done  <= 1'b0;
            r_ch    <= 1'b0;
            r_bg    <= '0;
            r_bank  <= '0;
            r_row   <= '0;
            r_col   <= '0;
`ifdef DDR5_REFRESH_EN
            r_refi        <= '0;
            r_ref_pending <= 1'b0;
            r_ref_active  <= 1'b0;
`endif
        end else begin
            r_cmd  <= CmdNop;
            r_done <= 1'b0;
            if (r_wait != '0) r_wait <= r_wait - One;
            if (r_ras != '0) r_ras <= r_ras - One;
`ifdef DDR5_REFRESH_EN
            if (r_refi == CW'(T_REFI - 1)) begin
                r_refi        <= '0;
                r_ref_pending <= 1'b1;
            end else begin
                r_refi <= r_refi + One;
            end
`endif
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_wr    <= (i_req_op == 2'd2);
                        r_ch    <= i_req_addr[6];
                        r_bg    <= i_req_addr[9:7];
                        r_bank  <= i_req_addr[11:10];
                        r_row   <= i_req_addr[33:18];
                        r_col   <= i_req_addr[17:12];
                        if (i_req_op != 2'd3) begin
                            r_state <= StAct0;
                            r_cmd   <= CmdAct0;
                            r_wait  <= CW'(T_RCD);
                            r_ras   <= CW'(T_RAS);
                        end
                    end
`ifdef DDR5_REFRESH_EN
                    else if (r_ref_pending) begin
                        r_ready      <= 1'b0;
                        r_state      <= StRef;
                        r_cmd        <= CmdRef;
                        r_wait       <= CW'(T_RFC);
                        r_ref_active <= 1'b1;
                        r_ch         <= 1'b0;
                        r_bg         <= '0;
                        r_bank       <= '0;
                        r_row        <= '0;
                        r_col        <= '0;
                    end
`endif
                    else begin
                        r_ready <= 1'b1;
                    end
                end
                StAct0: begin
                    r_state <= StAct1;
                    r_cmd   <= CmdAct1;
                end
                StAct1, StTrcd: begin
                    if (r_wait <= One) begin
                        r_state <= StCol0;
                        r_cmd   <= r_wr ? CmdWr0 : CmdRd0;
                        r_wait  <= r_wr ? CW'(T_WR) : CW'(T_RTP);
                    end else begin
                        r_state <= StTrcd;
                    end
                end
                StCol0: begin
                    r_state <= StCol1;
                    r_cmd   <= r_wr ? CmdWr1 : CmdRd1;
                end
                StCol1, StTpre: begin
                    if (r_ras <= One && r_wait <= One) begin
                        r_state <= StPre;
                        r_cmd   <= CmdPre;
                        r_done  <= 1'b1;
                        r_wait  <= CW'(T_RP);
                    end else begin
                        r_state <= StTpre;
                    end
                end
                StPre, StTrp: begin
                    if (r_wait <= One) begin
                        r_state <= StIdle;
                        r_ready <= !w_ref_pending;
                    end else begin
                        r_state <= StTrp;
                    end
                end
`ifdef DDR5_REFRESH_EN
                StRef, StTrfc: begin
                    if (r_wait <= One) begin
                        r_state       <= StIdle;
                        r_ready       <= 1'b1;
                        r_ref_active  <= 1'b0;
                        r_ref_pending <= 1'b0;
                    end else begin
                        r_state <= StTrfc;
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready   = r_ready;
    assign o_cmd_code    = r_cmd;
    assign o_req_done    = r_done;
    assign o_cmd_channel = r_ch;
    assign o_cmd_bg      = r_bg;
    assign o_cmd_bank    = r_bank;
    assign o_cmd_row     = r_row;
    assign o_cmd_col     = r_col;

endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Directed bench for ddr5_cmd_scheduler with default timing; with DDR5_REFRESH_EN defined it
// instead runs continuous reads against T_REFI=200 and checks refresh placement.
module tb_ddr5_cmd_scheduler;
`ifdef DDR5_REFRESH_EN
    localparam int unsigned TRefi = 200;
`else
    localparam int unsigned TRefi = 9360;
`endif
    localparam int TRp  = 39;
    localparam int TRfc = 708;

    localparam logic [3:0] NOP = 4'd0, ACT0 = 4'd1, ACT1 = 4'd2, RD0 = 4'd3, RD1 = 4'd4;
    localparam logic [3:0] WR0 = 4'd5, WR1 = 4'd6, PRE = 4'd7, REF = 4'd8;

    // Address A = 0x0_0003_C6C0: ch=1 bg=5 bank=1 row=0 col=0x3C
    localparam logic [35:0] AddrA = 36'h0_0003_C6C0;
    localparam logic [27:0] FldA  = {1'b1, 3'd5, 2'd1, 16'h0000, 6'h3C};
    localparam logic [35:0] AddrB = {2'b10, 16'hBEEF, 6'h15, 2'd2, 3'd6, 1'b0, 6'h2A};
    localparam logic [27:0] FldB  = {1'b0, 3'd6, 2'd2, 16'hBEEF, 6'h15};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [35:0] req_addr = '0;
    logic        req_ready, cmd_channel, req_done, ref_active;
    logic [3:0]  cmd_code;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [5:0]  cmd_col;
    logic [27:0] w_fields;

    int n_assert = 0;
    int n_fail   = 0;

    assign w_fields = {cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col};

    ddr5_cmd_scheduler #(.T_REFI(TRefi)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op      (req_op),
        .i_req_addr    (req_addr),
        .o_cmd_code    (cmd_code),
        .o_cmd_channel (cmd_channel),
        .o_cmd_bg      (cmd_bg),
        .o_cmd_bank    (cmd_bank),
        .o_cmd_row     (cmd_row),
        .o_cmd_col     (cmd_col),
        .o_req_done    (req_done),
        .o_ref_active  (ref_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with ready high; ends at the negedge of cycle c_rdy (ready high again).
    task automatic run_req(input string tag, input logic [1:0] op, input logic [35:0] addr,
                           input logic [27:0] exp_f, input int c_col, input int c_pre,
                           input int c_rdy, input bit keep);
        int dones;
        logic [3:0] exp_cmd;
        dones = 0;
        chk({tag, " ready_at_start"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        @(posedge clk);
        for (int cyc = 0; cyc <= c_rdy; cyc++) begin
            @(negedge clk);
            if (cyc == 0 && !keep) req_valid = 1'b0;
            if (cyc == 0) exp_cmd = ACT0;
            else if (cyc == 1) exp_cmd = ACT1;
            else if (cyc == c_col) exp_cmd = (op == 2'd2) ? WR0 : RD0;
            else if (cyc == c_col + 1) exp_cmd = (op == 2'd2) ? WR1 : RD1;
            else if (cyc == c_pre) exp_cmd = PRE;
            else exp_cmd = NOP;
            chk($sformatf("%s cmd@%0d", tag, cyc), 64'(cmd_code), 64'(exp_cmd));
            chk($sformatf("%s done@%0d", tag, cyc), 64'(req_done), 64'(cyc == c_pre));
            chk($sformatf("%s ready@%0d", tag, cyc), 64'(req_ready), 64'(cyc == c_rdy));
            chk($sformatf("%s fields@%0d", tag, cyc), 64'(w_fields), 64'(exp_f));
            chk($sformatf("%s ref_active@%0d", tag, cyc), 64'(ref_active), 64'(0));
            if (req_done) dones++;
        end
        chk({tag, " done_count"}, 64'(dones), 64'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 64'(req_ready), 64'(0));
        chk("reset cmd", 64'(cmd_code), 64'(0));
        chk("reset fields", 64'(w_fields), 64'(0));
        chk("reset done", 64'(req_done), 64'(0));
        chk("reset ref_active", 64'(ref_active), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", 64'(req_ready), 64'(1));

`ifdef DDR5_REFRESH_EN
        begin
            int last_pre, last_ref, last_cmd, refs, acts, run, bad_len, bad_ref, act_rfc;
            last_pre = -100000; last_ref = -100000; last_cmd = 0;
            refs = 0; acts = 0; run = 0; bad_len = 0; bad_ref = 0; act_rfc = 0;
            req_valid = 1'b1;
            req_op    = 2'd0;
            req_addr  = AddrA;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (cmd_code == REF) begin
                    refs++;
                    if (last_cmd != int'(PRE) || cyc - last_pre < TRp + 1) bad_ref++;
                    chk("ref fields", 64'(w_fields), 64'(0));
                    chk("ref_active at REF", 64'(ref_active), 64'(1));
                    last_ref = cyc;
                end
                if (cmd_code == ACT0) begin
                    acts++;
                    if (cyc - last_ref <= TRfc) act_rfc++;
                end
                if (cmd_code == PRE) last_pre = cyc;
                if (cmd_code != NOP) last_cmd = int'(cmd_code);
                if (ref_active) run++;
                else begin
                    if (run != 0 && run != TRfc) bad_len++;
                    run = 0;
                end
            end
            req_valid = 1'b0;
            chk("refresh count >= 2", 64'(refs >= 2), 64'(1));
            chk("act count >= 3", 64'(acts >= 3), 64'(1));
            chk("ref placement", 64'(bad_ref), 64'(0));
            chk("act inside tRFC", 64'(act_rfc), 64'(0));
            chk("ref_active length", 64'(bad_len), 64'(0));
        end
`else
        run_req("rd", 2'd0, AddrA, FldA, 39, 76, 115, 1'b0);
        run_req("wr", 2'd2, AddrA, FldA, 39, 157, 196, 1'b0);
        // valid stays high across both: second ACT0 lands 116 cycles after the first
        run_req("b2b_1", 2'd0, AddrA, FldA, 39, 76, 115, 1'b1);
        run_req("b2b_2", 2'd0, AddrB, FldB, 39, 76, 115, 1'b0);

        chk("op3 ready_at_start", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = 2'd3;
        req_addr  = AddrB;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("op3 cmd+0", 64'(cmd_code), 64'(NOP));
        chk("op3 done+0", 64'(req_done), 64'(0));
        @(negedge clk);
        chk("op3 cmd+1", 64'(cmd_code), 64'(NOP));
        chk("op3 ready+1", 64'(req_ready), 64'(1));
        run_req("ifetch", 2'd1, AddrA, FldA, 39, 76, 115, 1'b0);

        req_valid = 1'b1;
        req_op    = 2'd0;
        req_addr  = AddrA;
        @(posedge clk);
        for (int cyc = 0; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (cyc == 0) req_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst cmd", 64'(cmd_code), 64'(0));
        chk("midrst ready", 64'(req_ready), 64'(0));
        chk("midrst fields", 64'(w_fields), 64'(0));
        chk("midrst done", 64'(req_done), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("midrst ready after release", 64'(req_ready), 64'(1));
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            chk($sformatf("midrst no_pre@%0d", cyc), 64'(cmd_code), 64'(NOP));
            chk($sformatf("midrst no_done@%0d", cyc), 64'(req_done), 64'(0));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
